// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline registers.
// Handles load-use bubbles, multi-cycle memory freezes and branch squash.
module pipeline_hazard_controller #(
    parameter int REG_W   = 4,
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mm,
    input  logic             ex_wbs,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int CW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 2);
    localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic pc_en_c, ifid_en_c, ifid_fl_c;
    logic idex_en_c, idex_fl_c, exmem_en_c, bub_c;
    logic luh;

    assign luh = ex_mm && ex_wbs && (ex_rd != '0) &&
                 ((ex_rd == id_rs1) ||
                  (id_uses_rs2 && (ex_rd == id_rs2)));

    always_comb begin
        pc_en_c    = 1'b1;
        ifid_en_c  = 1'b1;
        ifid_fl_c  = 1'b0;
        idex_en_c  = 1'b1;
        idex_fl_c  = 1'b0;
        exmem_en_c = 1'b1;
        bub_c      = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        unique case (state_q)
            RUN: begin
                if (mem_req) begin
                    {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = '0;
                    bub_c   = 1'b1;
                    cnt_d   = CNT_INIT;
                    pend_d  = 1'b0;
                    state_d = MEM_WAIT;
                end else if (ex_branch_taken) begin
                    ifid_fl_c = 1'b1;
                    idex_fl_c = 1'b1;
                    state_d   = FLUSH;
                end else if (luh) begin
                    pc_en_c   = 1'b0;
                    ifid_en_c = 1'b0;
                    idex_fl_c = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (cnt_q != '0) begin
                    {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = '0;
                    bub_c = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = pend_q ? FLUSH : RUN;
                    pend_d  = 1'b0;
                end
            end
            FLUSH: begin
                if (mem_req) begin
                    {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = '0;
                    bub_c   = 1'b1;
                    cnt_d   = CNT_INIT;
                    pend_d  = 1'b1;
                    state_d = MEM_WAIT;
                end else begin
                    ifid_fl_c = 1'b1;
                    state_d   = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_en_c && (stall_q != SAT)) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            stall_q <= stall_d;
        end
    end

    // Everything reads as zero while reset is held, even mid-access.
    assign pc_en        = rst_n & pc_en_c;
    assign ifid_en      = rst_n & ifid_en_c;
    assign ifid_flush   = rst_n & ifid_fl_c;
    assign idex_en      = rst_n & idex_en_c;
    assign idex_flush   = rst_n & idex_fl_c;
    assign exmem_en     = rst_n & exmem_en_c;
    assign memwb_bubble = rst_n & bub_c;
    assign state        = rst_n ? state_q : 2'b00;
    assign stall_cycles = stall_q;

endmodule
